// File: rtl/kbd_ps2_port.sv
// PS/2 keyboard port: synchronises the PS/2 lines, deframes and checks 11-bit frames, and queues good scancodes in a FIFO that the CPU reads.
// Latency: a PS/2 falling edge acts 3 clk edges after the pin changes; CPU read data is combinational and pops take effect at the next edge.
// Backpressure: none toward the keyboard; a scancode arriving at a full FIFO is dropped and sets a sticky overflow flag.
module kbd_ps2_port #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic        rd_en,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] dout,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Synchroniser and edge-detect registers; idle PS/2 lines are high.
    logic clk_s1, clk_s2, clk_prev;
    logic dat_s1, dat_s2;
    logic fall;

    // Frame receiver state.
    state_t        state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          parity_bit;
    logic [TW-1:0] to_cnt;
    logic          frame_push;

    // Scancode FIFO state.
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count, count_next;
    logic          overflow;
    logic          empty, full;
    logic          flush, pop_req, do_pop, do_push, ovf_set;
    logic [7:0]    head;
    logic [7:0]    cnt8;
    logic          unused_bits;

    assign unused_bits = ^{addr[31:3], addr[1:0], din[31:1]};

    // Two-stage synchronisers plus a delayed clock copy for falling-edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    // A completed frame is good when the stop bit is 1 and data+parity has odd weight.
    assign frame_push = (state == ST_STOP) && fall && dat_s2 && (^{shreg, parity_bit});

    // Frame FSM: start, 8 data bits LSB first, parity, stop; abandons a stalled frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bitcnt     <= 3'd0;
            shreg      <= 8'd0;
            parity_bit <= 1'b0;
            to_cnt     <= '0;
        end else begin
            if (state == ST_IDLE || fall) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (state != ST_IDLE && !fall && to_cnt == TO_LAST) begin
                state <= ST_IDLE;
            end else if (fall) begin
                case (state)
                    ST_IDLE: begin
                        // A falling edge with data high is not a start bit.
                        if (!dat_s2) begin
                            state  <= ST_DATA;
                            bitcnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shreg  <= {dat_s2, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_bit <= dat_s2;
                        state      <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign flush   = sel & we & addr[2] & din[0];
    assign pop_req = sel & rd_en & ~addr[2];

    // Flush wins over everything; a pop on a full FIFO makes room for a same-cycle push.
    assign do_pop  = pop_req & ~empty & ~flush;
    assign do_push = frame_push & ~flush & (~full | do_pop);
    assign ovf_set = frame_push & ~flush & full & ~do_pop;

    // Next occupancy, shared by the count register and the interrupt flag.
    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_next = count - 1'b1;
        end
    end

    // Scancode storage; contents are only visible while count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= shreg;
        end
    end

    // Pointers, occupancy, sticky overflow and the interrupt line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            count <= count_next;
            irq   <= (count_next != '0);
            if (flush) begin
                wptr     <= '0;
                rptr     <= '0;
                overflow <= 1'b0;
            end else begin
                if (do_push) begin
                    wptr <= wptr + 1'b1;
                end
                if (do_pop) begin
                    rptr <= rptr + 1'b1;
                end
                if (ovf_set) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    assign head = mem[rptr];
    assign cnt8 = 8'(count);

    // CPU read mux: DATA shows valid+head, STATUS shows overflow and count; zero when unselected.
    always_comb begin
        dout = 32'd0;
        if (sel) begin
            if (!addr[2]) begin
                if (!empty) begin
                    dout = {23'd0, 1'b1, head};
                end
            end else begin
                dout = {overflow, 23'd0, cnt8};
            end
        end
    end

endmodule

// File: tb/tb_kbd_ps2_port.sv
// Bench for kbd_ps2_port: directed PS/2 frames plus randomised frames and CPU traffic,
// checked every cycle against a queue-based model of the scancode FIFO.
module tb_kbd_ps2_port;

    localparam int DEPTH = 8;
    localparam int TO    = 100;
    localparam int HALF  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        rd_en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic        ps2_clk;
    logic        ps2_data;
    logic [31:0] dout;
    logic        irq;

    kbd_ps2_port #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .rd_en    (rd_en),
        .we       (we),
        .addr     (addr),
        .din      (din),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .dout     (dout),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Model state: FIFO contents as a queue, overflow flag, and the one pending frame completion.
    logic [7:0] mq[$];
    bit         movf;
    int         cyc_count;
    int         push_at;
    logic [7:0] push_byte;
    logic       push_par;
    logic       push_stop;

    // Literal-expectation handshake between the stimulus and the compare process.
    int          lit_req;
    int          lit_ack;
    logic [31:0] lit_dout;
    logic        lit_irq;
    string       lit_name;

    int n_checks;
    int n_errors;

    initial begin
        cyc_count = 0;
        push_at   = -1;
        push_byte = 8'd0;
        push_par  = 1'b0;
        push_stop = 1'b0;
        lit_req   = 0;
        lit_dout  = 32'd0;
        lit_irq   = 1'b0;
        lit_name  = "";
    end

    // Model update at each clock edge: flush, else pop then push.
    always @(posedge clk) begin
        cyc_count = cyc_count + 1;
        if (!rst_n) begin
            mq.delete();
            movf = 1'b0;
        end else begin
            bit fl, pp, ps;
            fl = sel && we && addr[2] && din[0];
            pp = sel && rd_en && !addr[2] && (mq.size() != 0);
            ps = (cyc_count == push_at) && push_stop && ((^push_byte ^ push_par) == 1'b1);
            if (fl) begin
                mq.delete();
                movf = 1'b0;
            end else begin
                if (pp) void'(mq.pop_front());
                if (ps) begin
                    if (mq.size() < DEPTH) mq.push_back(push_byte);
                    else movf = 1'b1;
                end
            end
        end
    end

    // Compare process: DUT vs model every cycle, plus any pending literal expectation.
    initial begin
        logic [31:0] exp_d;
        logic        exp_i;
        n_checks = 0;
        n_errors = 0;
        lit_ack  = 0;
        forever begin
            @(posedge clk);
            #1;
            exp_d = 32'd0;
            if (sel) begin
                if (!addr[2]) begin
                    if (mq.size() != 0) exp_d = {23'd0, 1'b1, mq[0]};
                end else begin
                    exp_d = {movf, 23'd0, 8'(mq.size())};
                end
            end
            exp_i = (mq.size() != 0);
            n_checks++;
            if (dout !== exp_d) begin
                n_errors++;
                $display("FAIL model_dout t=%0t: got %h, expected %h", $time, dout, exp_d);
            end
            n_checks++;
            if (irq !== exp_i) begin
                n_errors++;
                $display("FAIL model_irq t=%0t: got %b, expected %b", $time, irq, exp_i);
            end
            if (lit_req != lit_ack) begin
                lit_ack = lit_req;
                n_checks++;
                if (dout !== lit_dout) begin
                    n_errors++;
                    $display("FAIL %s dout: got %h, expected %h", lit_name, dout, lit_dout);
                end
                n_checks++;
                if (irq !== lit_irq) begin
                    n_errors++;
                    $display("FAIL %s irq: got %b, expected %b", lit_name, irq, lit_irq);
                end
            end
        end
    end

    function automatic logic odd_par(input logic [7:0] b);
        return ~(^b);
    endfunction

    // Expect literal values after the coming clock edge.
    task automatic lit(input logic [31:0] d, input logic i, input string nm);
        lit_dout = d;
        lit_irq  = i;
        lit_name = nm;
        lit_req  = lit_req + 1;
        @(negedge clk);
    endtask

    task automatic idle_cpu();
        sel   = 1'b0;
        rd_en = 1'b0;
        we    = 1'b0;
        addr  = 32'd0;
        din   = 32'd0;
    endtask

    task automatic peek(input logic a2, input logic [31:0] d, input logic i, input string nm);
        sel   = 1'b1;
        rd_en = 1'b0;
        we    = 1'b0;
        addr  = a2 ? 32'd4 : 32'd0;
        lit(d, i, nm);
        idle_cpu();
    endtask

    task automatic pop_once();
        sel   = 1'b1;
        rd_en = 1'b1;
        we    = 1'b0;
        addr  = 32'd0;
        @(negedge clk);
        idle_cpu();
    endtask

    task automatic flush_fifo();
        sel   = 1'b1;
        we    = 1'b1;
        rd_en = 1'b0;
        addr  = 32'd4;
        din   = 32'd1;
        @(negedge clk);
        idle_cpu();
    endtask

    // Drive n PS/2 bits LSB first; the 11th bit's falling edge completes a frame.
    task automatic send_bits(input logic [10:0] bits, input int n, input bit pop_at_stop);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) begin
                push_byte = bits[8:1];
                push_par  = bits[9];
                push_stop = bits[10];
                push_at   = cyc_count + 3;
            end
            for (int k = 0; k < HALF; k++) begin
                @(negedge clk);
                if (pop_at_stop && i == 10 && k == 1) begin
                    sel = 1'b1; we = 1'b0; addr = 32'd0; rd_en = 1'b1;
                end
                if (pop_at_stop && i == 10 && k == 2) idle_cpu();
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input bit pop_at_stop);
        send_bits({stp, par, b, 1'b0}, 11, pop_at_stop);
    endtask

    bit ps2_done;

    initial begin
        idle_cpu();
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rst_n    = 1'b0;

        // Reset state
        sel = 1'b1; addr = 32'd0;
        lit(32'd0, 1'b0, "reset_data");
        addr = 32'd4;
        lit(32'd0, 1'b0, "reset_status");
        idle_cpu();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single good frame 0x1C, then read-pop
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        peek(1'b1, 32'h0000_0001, 1'b1, "t2_status");
        peek(1'b0, 32'h0000_011C, 1'b1, "t2_data");
        sel = 1'b1; rd_en = 1'b1; addr = 32'd0;
        lit(32'h0000_0000, 1'b0, "t2_after_pop");
        idle_cpu();

        // Bad parity and bad stop are dropped
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        peek(1'b1, 32'h0000_0000, 1'b0, "t3_status");

        // Overflow with nine frames
        for (int v = 1; v <= 9; v++) send_frame(8'(v), odd_par(8'(v)), 1'b1, 1'b0);
        peek(1'b1, 32'h8000_0008, 1'b1, "t4_status_full");
        for (int v = 1; v <= 8; v++) begin
            peek(1'b0, {23'd0, 1'b1, 8'(v)}, 1'b1, "t4_pop_order");
            pop_once();
        end
        peek(1'b0, 32'h0000_0000, 1'b0, "t4_empty_data");
        pop_once();
        peek(1'b1, 32'h8000_0000, 1'b0, "t4_status_ovf");
        sel = 1'b1; we = 1'b1; addr = 32'd4; din = 32'd1;
        lit(32'h0000_0000, 1'b0, "t4_flush");
        idle_cpu();

        // Partial frame abandoned by timeout
        send_bits({7'b0000000, 3'b101, 1'b0}, 4, 1'b0);
        repeat (TO + 1) @(negedge clk);
        send_frame(8'hF0, odd_par(8'hF0), 1'b1, 1'b0);
        peek(1'b1, 32'h0000_0001, 1'b1, "t5_status");
        peek(1'b0, 32'h0000_01F0, 1'b1, "t5_data");
        flush_fifo();

        // Full FIFO with a pop coinciding with the push of 0xAA
        for (int v = 16; v < 24; v++) send_frame(8'(v), odd_par(8'(v)), 1'b1, 1'b0);
        peek(1'b1, 32'h0000_0008, 1'b1, "t6_full");
        send_frame(8'hAA, odd_par(8'hAA), 1'b1, 1'b1);
        peek(1'b1, 32'h0000_0008, 1'b1, "t6_status_no_ovf");
        for (int v = 17; v < 24; v++) begin
            peek(1'b0, {23'd0, 1'b1, 8'(v)}, 1'b1, "t6_pop_order");
            pop_once();
        end
        peek(1'b0, 32'h0000_01AA, 1'b1, "t6_last");
        flush_fifo();

        // Random frames against random CPU traffic
        ps2_done = 1'b0;
        fork
            begin
                repeat (60) begin
                    int kind;
                    logic [7:0] b;
                    kind = $urandom_range(0, 19);
                    b = 8'($urandom);
                    if (kind < 12)      send_frame(b, odd_par(b), 1'b1, 1'b0);
                    else if (kind < 15) send_frame(b, ~odd_par(b), 1'b1, 1'b0);
                    else if (kind < 17) send_frame(b, odd_par(b), 1'b0, 1'b0);
                    else                send_bits(11'h7FF, 1, 1'b0);
                    repeat ($urandom_range(0, 20)) @(negedge clk);
                end
                ps2_done = 1'b1;
            end
            begin
                while (!ps2_done) begin
                    @(negedge clk);
                    sel   = ($urandom_range(0, 3) != 0);
                    rd_en = ($urandom_range(0, 47) == 0);
                    we    = ($urandom_range(0, 39) == 0);
                    addr  = $urandom;
                    din   = $urandom;
                end
            end
        join
        idle_cpu();
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/kbd_ps2_port.md
Name: kbd_ps2_port

Overview:
- Memory-mapped PS/2 keyboard peripheral: receives PS/2 frames, checks them, and buffers scancodes in a FIFO.
- Sits directly upstream of the address decoder: takes the keyboard select (id 4'h5), and its dout drives the decoder's dout_kbd input.
- The CPU reads scancodes from the data register (read-to-pop) and reads status/count from the status register.

Parameters:
- FIFO_DEPTH, 8, scancode FIFO entries; power of two, >= 2.
- TIMEOUT_CYCLES, 50000, clk cycles without a PS/2 falling edge before a partial frame is abandoned.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sel  input  1  peripheral select from the address decoder
- rd_en  input  1  CPU load strobe for this cycle
- we  input  1  CPU store strobe for this cycle
- addr  input  32  CPU byte address; only addr[2] is decoded (0 = DATA, 1 = STATUS)
- din  input  32  CPU store data
- ps2_clk  input  1  raw PS/2 clock (asynchronous)
- ps2_data  input  1  raw PS/2 data (asynchronous)
- dout  output  32  read data, combinational on addr and state
- irq  output  1  high while the FIFO is non-empty

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty, pointers 0, count 0, overflow 0, frame FSM IDLE, synchronizers all 1.
  - Outputs: dout=0, irq=0.
- Input synchronization: ps2_clk and ps2_data pass through 2 FFs each. A third ps2_clk register gives falling-edge detect: fall = prev & ~sync. Sampling happens only on fall.
- Frame FSM, 11 bits per frame:
  - IDLE: on fall, if data=0 go to DATA with bitcnt=0. If data=1, stay in IDLE (spurious edge).
  - DATA: on fall, shift data into shreg[7] and shift right (LSB first). After 8 bits go to PARITY.
  - PARITY: on fall, latch the parity bit and go to STOP.
  - STOP: on fall, the frame is good if stop=1 and ^{shreg, parity}=1 (odd). Good frame: push shreg. Bad frame: drop silently. Either way, go to IDLE.
  - Timeout: in any state other than IDLE, a cycle counter resets on every fall. Reaching TIMEOUT_CYCLES returns the FSM to IDLE and discards the partial frame.
- FIFO push (good frame):
  - Not full: write at wptr, wptr+1 (wraps modulo FIFO_DEPTH), count+1.
  - Full: byte dropped, overflow set sticky, FIFO unchanged.
- FIFO pop: in a cycle with sel & rd_en & addr[2]=0 & count!=0, rptr+1 (wraps) and count-1 at the clock edge. Pop on empty has no effect.
- Simultaneous push and pop:
  - Non-full, non-empty: both happen, count unchanged.
  - Full: the pop frees a slot, so the push is accepted. Overflow is not set.
  - Empty: the pop is ignored and the push is accepted.
- Read data (combinational, zero latency; both values are 0 when sel=0):
  - DATA: {23'b0, valid, head_byte}, where valid = (count!=0). When empty, the whole word is 0.
  - STATUS: {overflow, 15'b0, 8'b0, count} with count zero-extended into bits [7:0]; bit31 = overflow.
- Write: sel & we & addr[2]=1 with din[0]=1 flushes the FIFO (pointers and count to 0) and clears overflow. Writes to DATA are ignored.
  - A push in the same cycle as a flush is lost.
  - Flush has priority over pop.
- irq = (count!=0), registered from the count value.
- Reset mid-frame aborts the frame and empties the FIFO immediately (async).

Test Plan:
- Reset then idle: rst_n low for 3 cycles → dout=0 for both addresses, irq=0, status count=0.
- Valid frame for 0x1C (start 0, bits LSB first, parity 0, stop 1) → status reads 0x00000001; DATA reads 0x0000011C. Read-pop → next DATA read = 0x00000000, irq=0.
- Bad parity frame for 0x1C (parity 1) and a frame with stop=0 → both dropped, count stays 0.
- Send 9 good frames, 0x01..0x09, with FIFO_DEPTH=8 → status = 0x80000008. Pops return 0x01..0x08 in order; the 9th pop sees empty. Write din=1 to STATUS → status = 0x00000000.
- Partial frame (start + 3 bits), then TIMEOUT_CYCLES+1 idle clocks, then full frame 0xF0 → exactly one entry, value 0xF0.
- FIFO full with a pop in the same cycle as a STOP-bit push of 0xAA → count stays 8, overflow=0, and 0xAA is last out after 7 more pops.
